unpacked_serializer: RTL and testbench

Width converter that accepts a full unpacked vector of IN_NUM elements on a valid/ready handshake and emits it as IN_NUM/OUT_NUM consecutive beats of OUT_NUM elements, lowest-index elements first. It is the narrowing counterpart to the unpacked vector FIFO path. It sits between a wide buffered stage and a narrower downstream consumer, such as a reduced-parallelism arithmetic core. It is fully registered on the output and sustains one output beat per cycle with no bubble between vectors.

---
 rtl/unpacked_serializer.sv | 47 ++++
 tb/tb_unpacked_serializer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/unpacked_serializer.sv
// unpacked_serializer: narrows an IN_NUM-element vector into IN_NUM/OUT_NUM beats of OUT_NUM elements, lowest index first
module unpacked_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int IN_NUM = 8,
  parameter int OUT_NUM = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [IN_NUM-1:0],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [OUT_NUM-1:0],
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  data_out_last
);
  localparam int BEATS = IN_NUM / OUT_NUM;
  localparam int IW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int AW = IN_NUM > 1 ? $clog2(IN_NUM) : 1;
  if (IN_NUM % OUT_NUM != 0) begin : g_bad_ratio
    $error("IN_NUM must be a multiple of OUT_NUM");
  end
  logic [DATA_WIDTH-1:0] data_buf [IN_NUM-1:0];
  logic [IW-1:0] idx;
  logic full, in_hs, out_hs;
  assign data_out_valid = full;
  assign data_out_last = full && idx == IW'(BEATS - 1);
  assign data_in_ready = !rst && (!full || (data_out_last && data_out_ready));
  assign in_hs = data_in_valid && data_in_ready;
  assign out_hs = data_out_valid && data_out_ready;
  for (genvar j = 0; j < OUT_NUM; j++) begin : g_out
    assign data_out[j] = data_buf[AW'(int'(idx) * OUT_NUM + j)];
  end
  always_ff @(posedge clk)
    if (rst) begin
      full <= 1'b0;
      idx <= '0;
      data_buf <= '{default: '0};
    end else if (in_hs) begin
      data_buf <= data_in;
      full <= 1'b1;
      idx <= '0;
    end else if (out_hs) begin
      idx <= data_out_last ? '0 : idx + 1'b1;
      full <= !data_out_last;
    end
endmodule

// File: tb/tb_unpacked_serializer.sv
// tb_unpacked_serializer: directed and scoreboard checks of unpacked_serializer in 8/2, 4/4 and 6/3 configurations
module tb_unpacked_serializer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] a_in [7:0];
  logic [7:0] a_out [1:0];
  logic a_iv, a_ir, a_ov, a_or, a_last;
  logic [7:0] b_in [3:0];
  logic [7:0] b_out [3:0];
  logic b_iv, b_ir, b_ov, b_or, b_last;
  logic [7:0] c_in [5:0];
  logic [7:0] c_out [2:0];
  logic c_iv, c_ir, c_ov, c_or, c_last;

  unpacked_serializer #(.DATA_WIDTH(8), .IN_NUM(8), .OUT_NUM(2)) dut_a (
    .clk(clk), .rst(rst), .data_in(a_in), .data_in_valid(a_iv), .data_in_ready(a_ir),
    .data_out(a_out), .data_out_valid(a_ov), .data_out_ready(a_or), .data_out_last(a_last));
  unpacked_serializer #(.DATA_WIDTH(8), .IN_NUM(4), .OUT_NUM(4)) dut_b (
    .clk(clk), .rst(rst), .data_in(b_in), .data_in_valid(b_iv), .data_in_ready(b_ir),
    .data_out(b_out), .data_out_valid(b_ov), .data_out_ready(b_or), .data_out_last(b_last));
  unpacked_serializer #(.DATA_WIDTH(8), .IN_NUM(6), .OUT_NUM(3)) dut_c (
    .clk(clk), .rst(rst), .data_in(c_in), .data_in_valid(c_iv), .data_in_ready(c_ir),
    .data_out(c_out), .data_out_valid(c_ov), .data_out_ready(c_or), .data_out_last(c_last));

  int n_checks = 0;
  int n_fail = 0;
  int sent, got, beat, cyc;
  logic [7:0] sb [$];
  logic [15:0] exp1 [4] = '{16'h0201, 16'h0403, 16'h0605, 16'h0807};
  logic [15:0] exp2 [6] = '{16'h0201, 16'h0403, 16'h0403, 16'h0403, 16'h0605, 16'h0807};
  logic rdy2 [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [15:0] exp3 [8] = '{16'h1110, 16'h1312, 16'h1514, 16'h1716,
                            16'h2120, 16'h2322, 16'h2524, 16'h2726};
  logic [15:0] exp4 [4] = '{16'h4140, 16'h4342, 16'h4544, 16'h4746};
  logic [31:0] exp5 [4] = '{32'h53525150, 32'h63626160, 32'h73727170, 32'h83828180};

  task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  function automatic logic [15:0] pack_a();
    return {a_out[1], a_out[0]};
  endfunction
  function automatic logic [31:0] pack_b();
    return {b_out[3], b_out[2], b_out[1], b_out[0]};
  endfunction
  function automatic logic [23:0] pack_c();
    return {c_out[2], c_out[1], c_out[0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_iv = 1'b0; a_or = 1'b0; b_iv = 1'b0; b_or = 1'b0; c_iv = 1'b0; c_or = 1'b0;
    for (int i = 0; i < 8; i++) a_in[i] = 8'hff;
    for (int i = 0; i < 4; i++) b_in[i] = 8'hff;
    for (int i = 0; i < 6; i++) c_in[i] = 8'hff;
    tick();
    tick();
    check("rst_valid", a_ov, 0);
    check("rst_last", a_last, 0);
    check("rst_data", pack_a(), 0);
    check("rst_in_ready", a_ir, 0);
    check("rst_b_data", pack_b(), 0);
    check("rst_c_valid", c_ov, 0);
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", a_ir, 1);

    for (int i = 0; i < 8; i++) a_in[i] = 8'(i + 1);
    a_iv = 1'b1;
    a_or = 1'b1;
    tick();
    a_iv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("single_beat", pack_a(), exp1[k]);
      check("single_valid", a_ov, 1);
      check("single_last", a_last, k == 3);
      tick();
    end
    check("single_after_valid", a_ov, 0);

    a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    for (int k = 0; k < 6; k++) begin
      a_or = rdy2[k];
      #1;
      check("bp_beat", pack_a(), exp2[k]);
      check("bp_last", a_last, k == 5);
      check("bp_in_ready", a_ir, k == 5);
      tick();
    end
    check("bp_after_valid", a_ov, 0);
    a_or = 1'b1;

    for (int i = 0; i < 8; i++) a_in[i] = 8'(8'h10 + i);
    a_iv = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) a_in[i] = 8'(8'h20 + i);
    for (int k = 0; k < 8; k++) begin
      check("b2b_beat", pack_a(), exp3[k]);
      check("b2b_valid", a_ov, 1);
      check("b2b_last", a_last, k == 3 || k == 7);
      check("b2b_in_ready", a_ir, k == 3 || k == 7);
      tick();
      if (k == 3) a_iv = 1'b0;
    end
    check("b2b_after_valid", a_ov, 0);

    for (int i = 0; i < 8; i++) a_in[i] = 8'(8'h30 + i);
    a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    check("mid_beat0", pack_a(), 16'h3130);
    tick();
    check("mid_beat1", pack_a(), 16'h3332);
    tick();
    check("mid_beat2", pack_a(), 16'h3534);
    rst = 1'b1;
    #1;
    check("mid_in_ready_rst", a_ir, 0);
    tick();
    check("mid_rst_valid", a_ov, 0);
    check("mid_rst_last", a_last, 0);
    check("mid_rst_data", pack_a(), 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) a_in[i] = 8'(8'h40 + i);
    a_iv = 1'b1;
    tick();
    a_iv = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("after_rst_beat", pack_a(), exp4[k]);
      check("after_rst_last", a_last, k == 3);
      tick();
    end
    check("after_rst_valid", a_ov, 0);

    b_or = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) b_in[i] = 8'(8'h50 + 16 * k + i);
      b_iv = 1'b1;
      tick();
      check("deg_beat", pack_b(), exp5[k]);
      check("deg_valid", b_ov, 1);
      check("deg_last", b_last, 1);
      check("deg_in_ready", b_ir, 1);
    end
    b_iv = 1'b0;
    tick();
    check("deg_after_valid", b_ov, 0);
    check("deg_after_last", b_last, 0);

    sent = 0; got = 0; beat = 0; cyc = 0;
    while (got < 1000 && cyc < 20000) begin
      c_iv = sent < 1000 && $urandom_range(3) != 0;
      for (int i = 0; i < 6; i++) c_in[i] = 8'($urandom);
      c_or = $urandom_range(3) != 0;
      #1;
      if (c_ov && c_or) begin
        if (sb.size() < 3) check("rand_underflow", sb.size(), 3);
        else begin
          check("rand_beat", pack_c(), {sb[2], sb[1], sb[0]});
          repeat (3) void'(sb.pop_front());
        end
        check("rand_last", c_last, beat == 1);
        if (beat == 1) got++;
        beat = 1 - beat;
      end
      if (c_iv && c_ir) begin
        for (int i = 0; i < 6; i++) sb.push_back(c_in[i]);
        sent++;
      end
      tick();
      cyc++;
    end
    c_iv = 1'b0;
    check("rand_vectors_done", got, 1000);
    check("rand_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
